// File: rtl/csr_if.sv
// CSR access port between decode and the CSR unit: address, op, write data
// in; old value and illegal flag back, both combinational.
interface csr_if #(
   parameter int unsigned XLEN = 32
) ();
   logic [11:0]     csr_addr;
   logic [1:0]      csr_op;
   logic [XLEN-1:0] csr_w_data;
   logic [XLEN-1:0] csr_r_data;
   logic            csr_illegal;

   modport master (output csr_addr, csr_op, csr_w_data, input csr_r_data, csr_illegal);
   modport slave  (input csr_addr, csr_op, csr_w_data, output csr_r_data, csr_illegal);
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/write/set/clear, trap entry and mret
// updates, 64-bit mcycle/minstret counters and external interrupt pending.
module csr_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0,
   parameter logic [XLEN-1:0] HART_ID     = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   csr_if.slave            bus,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret_en,
   input  logic            instret_inc,
   input  logic            irq_ext,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_out,
   output logic            irq_pending
);
   localparam int unsigned CNT_W = 64;
   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;
   localparam logic [1:0]  OP_RW       = 2'b01;
   localparam logic [1:0]  OP_RS       = 2'b10;
   localparam logic [1:0]  OP_RC       = 2'b11;
   localparam logic [1:0]  MXL         = (XLEN == 64) ? 2'd2 : 2'd1;
   localparam logic [XLEN-1:0] MISA_VAL = (XLEN'(MXL) << (XLEN - 2)) | XLEN'(256);

   logic             mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
   logic [XLEN-1:0]  mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
   logic [XLEN-1:0]  mcause_q, mcause_d, mtval_q, mtval_d;
   logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   logic            known, read_only, is_write, illegal, wr_en;
   logic [XLEN-1:0] old_val, wval, tvec_base;

   // Address decode and old-value mux
   always_comb begin
      known     = 1'b1;
      read_only = 1'b0;
      old_val   = '0;
      case (bus.csr_addr)
         A_MSTATUS: begin
            old_val[3]     = mie_q;
            old_val[7]     = mpie_q;
            old_val[12:11] = 2'b11;
         end
         A_MISA:      begin old_val = MISA_VAL; read_only = 1'b1; end
         A_MIE:       old_val[11] = meie_q;
         A_MTVEC:     old_val = mtvec_q;
         A_MSCRATCH:  old_val = mscratch_q;
         A_MEPC:      old_val = mepc_q;
         A_MCAUSE:    old_val = mcause_q;
         A_MTVAL:     old_val = mtval_q;
         A_MIP:       begin old_val[11] = irq_ext; read_only = 1'b1; end
         A_MCYCLE:    old_val = mcycle_q[XLEN-1:0];
         A_MINSTRET:  old_val = minstret_q[XLEN-1:0];
         A_MCYCLEH:   if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);   else known = 1'b0;
         A_MINSTRETH: if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]); else known = 1'b0;
         A_MHARTID:   begin old_val = HART_ID; read_only = 1'b1; end
         default:     known = 1'b0;
      endcase
   end

   // Set/clear with a zero mask is a pure read, so it is legal on read-only CSRs
   always_comb begin
      is_write = (bus.csr_op == OP_RW) || (bus.csr_op[1] && (bus.csr_w_data != '0));
      illegal  = !known || (is_write && read_only);
      wr_en    = is_write && !illegal && !trap_en && !mret_en;
      case (bus.csr_op)
         OP_RW:   wval = bus.csr_w_data;
         OP_RS:   wval = old_val | bus.csr_w_data;
         OP_RC:   wval = old_val & ~bus.csr_w_data;
         default: wval = old_val;
      endcase
   end

   assign bus.csr_r_data  = illegal ? '0 : old_val;
   assign bus.csr_illegal = illegal;

   // Next state: trap beats mret beats CSR write; counters tick unless written
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + CNT_W'(1);
      minstret_d = minstret_q + CNT_W'(instret_inc);
      if (trap_en) begin
         mepc_d   = trap_pc & ~XLEN'(3);
         mcause_d = trap_cause;
         mtval_d  = trap_val;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_en) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (wr_en) begin
         case (bus.csr_addr)
            A_MSTATUS:  begin mie_d = wval[3]; mpie_d = wval[7]; end
            A_MIE:      meie_d = wval[11];
            A_MTVEC:    mtvec_d = {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
            A_MSCRATCH: mscratch_d = wval;
            A_MEPC:     mepc_d = wval & ~XLEN'(3);
            A_MCAUSE:   mcause_d = wval;
            A_MTVAL:    mtval_d = wval;
            A_MCYCLE:    begin mcycle_d = mcycle_q;     mcycle_d[XLEN-1:0] = wval;   end
            A_MINSTRET:  begin minstret_d = minstret_q; minstret_d[XLEN-1:0] = wval; end
            A_MCYCLEH:   begin mcycle_d = mcycle_q;     mcycle_d[63:32] = wval[31:0];   end
            A_MINSTRETH: begin minstret_d = minstret_q; minstret_d[63:32] = wval[31:0]; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtvec_q    <= RESET_MTVEC;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         meie_q     <= meie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   // Vectored interrupts land at BASE + 4*cause; everything else at BASE
   always_comb begin
      tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
      if ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1])
         trap_vector = tvec_base + {trap_cause[XLEN-3:0], 2'b00};
      else
         trap_vector = tvec_base;
   end

   assign mepc_out    = mepc_q;
   assign irq_pending = mie_q & meie_q & irq_ext;
endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit (XLEN=32): expectations are queued as each
// cycle is driven and drained against the DUT on the following falling edge.
module tb_csr_unit;
   localparam int unsigned XLEN = 32;
   localparam logic [31:0] RST_TVEC = 32'h0000_0040;
   localparam logic [31:0] HARTID   = 32'h0000_0005;
   localparam int SIG_RDATA = 0, SIG_ILL = 1, SIG_TVEC = 2, SIG_MEPC = 3, SIG_IRQ = 4;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   logic        clock, reset_n;
   logic        trap_en, mret_en, instret_inc, irq_ext, irq_pending;
   logic [31:0] trap_cause, trap_pc, trap_val, trap_vector, mepc_out;
   exp_t        sb[$];
   int          n_checks, n_fail;

   csr_if #(.XLEN(XLEN)) bus ();

   csr_unit #(.XLEN(XLEN), .RESET_MTVEC(RST_TVEC), .HART_ID(HARTID)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus),
      .trap_en(trap_en), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
      .mret_en(mret_en), .instret_inc(instret_inc), .irq_ext(irq_ext),
      .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   // Drain every queued expectation against the settled combinational outputs
   always @(negedge clock) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] obs;
         e = sb.pop_front();
         case (e.sig)
            SIG_RDATA: obs = bus.csr_r_data;
            SIG_ILL:   obs = 32'(bus.csr_illegal);
            SIG_TVEC:  obs = trap_vector;
            SIG_MEPC:  obs = mepc_out;
            default:   obs = 32'(irq_pending);
         endcase
         check(e.tag, obs, e.val);
      end
   end

   task automatic idle();
      bus.csr_addr   = 12'h000;
      bus.csr_op     = 2'b00;
      bus.csr_w_data = 32'h0;
      trap_en        = 1'b0;
      trap_cause     = 32'h0;
      trap_pc        = 32'h0;
      trap_val       = 32'h0;
      mret_en        = 1'b0;
      instret_inc    = 1'b0;
   endtask

   task automatic tick();
      @(negedge clock);
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic acc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
      bus.csr_addr   = a;
      bus.csr_op     = op;
      bus.csr_w_data = w;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      acc(a, 2'b00, 32'h0);
      expect_val(tag, SIG_RDATA, exp);
      tick();
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
      acc(a, op, w);
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle();
      irq_ext = 1'b1;
      reset_n = 1'b0;
      expect_val("rst_mepc_out", SIG_MEPC, 32'h0);
      expect_val("rst_irq_pending", SIG_IRQ, 32'h0);
      tick();
      irq_ext = 1'b0;
      reset_n = 1'b1;
      rd("rst_mcycle", 12'hB00, 32'h0);
      rd("mcycle_first_edge", 12'hB00, 32'h1);
      rd("rst_mstatus", 12'h300, 32'h0000_1800);
      rd("rst_mtvec", 12'h305, RST_TVEC);

      acc(12'h305, 2'b01, 32'h1000_0001);
      expect_val("rw_mtvec_old", SIG_RDATA, RST_TVEC);
      tick();
      rd("mtvec_rw", 12'h305, 32'h1000_0001);
      wr(12'h305, 2'b10, 32'h0000_0002);
      wr(12'h305, 2'b11, 32'h0000_0001);
      rd("mtvec_mode_legal", 12'h305, 32'h1000_0000);
      wr(12'h341, 2'b01, 32'h0000_0123);
      expect_val("mepc_out_align", SIG_MEPC, 32'h0000_0120);
      rd("mepc_align", 12'h341, 32'h0000_0120);

      // Trap entry with a CSR write in the same cycle
      wr(12'h340, 2'b01, 32'h0000_0011);
      wr(12'h300, 2'b01, 32'h0000_0008);
      rd("mstatus_mie", 12'h300, 32'h0000_1808);
      wr(12'h305, 2'b01, 32'h0000_0101);
      acc(12'h340, 2'b01, 32'h0000_DEAD);
      trap_en = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0204; trap_val = 32'h0000_0055;
      expect_val("trap_pre_read", SIG_RDATA, 32'h0000_0011);
      expect_val("trap_vector_irq", SIG_TVEC, 32'h0000_012C);
      tick();
      expect_val("trap_mepc_out", SIG_MEPC, 32'h0000_0204);
      rd("trap_mepc", 12'h341, 32'h0000_0204);
      rd("trap_mstatus", 12'h300, 32'h0000_1880);
      rd("trap_mscratch_kept", 12'h340, 32'h0000_0011);
      rd("trap_mcause", 12'h342, 32'h8000_000B);
      rd("trap_mtval", 12'h343, 32'h0000_0055);
      trap_cause = 32'h0000_0002;
      expect_val("trap_vector_exc", SIG_TVEC, 32'h0000_0100);
      tick();

      acc(12'h340, 2'b01, 32'h0000_0077);
      mret_en = 1'b1;
      tick();
      rd("mret_mstatus", 12'h300, 32'h0000_1888);
      rd("mret_mscratch_kept", 12'h340, 32'h0000_0011);

      // Illegal and read-only accesses
      acc(12'hF14, 2'b01, 32'h0000_0099);
      expect_val("ro_write_ill", SIG_ILL, 32'h1);
      expect_val("ro_write_rdata", SIG_RDATA, 32'h0);
      tick();
      acc(12'hF14, 2'b10, 32'h0);
      expect_val("rs0_hartid_ill", SIG_ILL, 32'h0);
      expect_val("rs0_hartid", SIG_RDATA, HARTID);
      tick();
      acc(12'hF14, 2'b11, 32'h1);
      expect_val("rc1_hartid_ill", SIG_ILL, 32'h1);
      tick();
      acc(12'h7C0, 2'b00, 32'h0);
      expect_val("unknown_ill", SIG_ILL, 32'h1);
      expect_val("unknown_rdata", SIG_RDATA, 32'h0);
      tick();
      acc(12'h301, 2'b01, 32'h0);
      expect_val("misa_write_ill", SIG_ILL, 32'h1);
      tick();
      rd("misa", 12'h301, 32'h4000_0100);
      rd("mscratch_after_ill", 12'h340, 32'h0000_0011);

      // Counter carry, wrap and write precedence
      wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
      rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycleh_carry", 12'hB80, 32'h0000_0001);
      wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
      wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
      rd("mcycleh_ones", 12'hB80, 32'hFFFF_FFFF);
      rd("mcycle_wrap_lo", 12'hB00, 32'h0);
      rd("mcycle_wrap_hi", 12'hB80, 32'h0);
      acc(12'hB02, 2'b01, 32'h0000_1000);
      instret_inc = 1'b1;
      tick();
      acc(12'hB02, 2'b00, 32'h0);
      instret_inc = 1'b1;
      expect_val("minstret_write_wins", SIG_RDATA, 32'h0000_1000);
      tick();
      rd("minstret_inc", 12'hB02, 32'h0000_1001);
      rd("minstreth", 12'hB82, 32'h0);

      // External interrupt pending
      wr(12'h304, 2'b01, 32'hFFFF_FFFF);
      rd("mie_mask", 12'h304, 32'h0000_0800);
      irq_ext = 1'b1;
      acc(12'h344, 2'b00, 32'h0);
      expect_val("irq_pending_set", SIG_IRQ, 32'h1);
      expect_val("mip_meip", SIG_RDATA, 32'h0000_0800);
      tick();
      wr(12'h300, 2'b11, 32'h0000_0008);
      expect_val("irq_pending_mie0", SIG_IRQ, 32'h0);
      tick();
      irq_ext = 1'b0;

      // Reset in the middle of operation
      reset_n = 1'b0;
      acc(12'h341, 2'b00, 32'h0);
      expect_val("midrst_mepc", SIG_RDATA, 32'h0);
      expect_val("midrst_mepc_out", SIG_MEPC, 32'h0);
      tick();
      reset_n = 1'b1;
      rd("midrst_mtvec", 12'h305, RST_TVEC);
      rd("midrst_mcycle", 12'hB00, 32'h1);
      rd("midrst_mscratch", 12'h340, 32'h0);

      @(negedge clock);
      #1;
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
